// File: rtl/seq_frame_pkg.sv
// Shared constants, FSM states and checksum for the serial frame link.
// Used by both the transmitter and the receiver side.
package seq_frame_pkg;

  localparam int BYTE_W       = 8;
  localparam int PAYLOAD_BITS = 40;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    PAYLOAD,
    GAP
  } state_t;

  function automatic logic [BYTE_W-1:0] frame_checksum(
    input logic [BYTE_W-1:0] d0,
    input logic [BYTE_W-1:0] d1,
    input logic [BYTE_W-1:0] d2,
    input logic [BYTE_W-1:0] d3
  );
    return d0 + d1 + d2 + d3;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// 40-bit parallel-in serial-out register for the frame payload.
// MSB is presented first; shifting fills zeros from the bottom.
module seq_piso
  import seq_frame_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_shift,
  input  logic [PAYLOAD_BITS-1:0] i_data,
  output logic                    o_msb
);

  logic [PAYLOAD_BITS-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_data;
    end else if (i_shift) begin
      r_sh <= {r_sh[PAYLOAD_BITS-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[PAYLOAD_BITS-1];

endmodule

// File: rtl/seq_wr.sv
// Serial frame transmitter: header, four data bytes and checksum,
// all MSB first, one bit per clock, with an idle gap between frames.
module seq_wr
  import seq_frame_pkg::*;
#(
  parameter int                  HEAD_LEN   = 8,
  parameter logic [HEAD_LEN-1:0] HEAD_PAT   = 8'b1011_0001,
  parameter logic                IDLE_BIT   = 1'b0,
  parameter int                  GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data0,
  input  logic [BYTE_W-1:0] in_data1,
  input  logic [BYTE_W-1:0] in_data2,
  input  logic [BYTE_W-1:0] in_data3,
  output logic              data_out,
  output logic              tx_active,
  output logic              frame_done
);

  state_t        r_state;
  logic [5:0]    r_cnt;
  logic          r_in_ready;
  logic          r_data_out;
  logic          r_tx_active;
  logic          r_frame_done;

  logic                    w_accept;
  logic                    w_shift;
  logic                    w_msb;
  logic [5:0]              w_cnt_dec;
  logic [HEAD_LEN-1:0]     w_hpat;
  logic [PAYLOAD_BITS-1:0] w_frame;

  assign w_accept  = in_valid & r_in_ready & (r_state == IDLE);
  assign w_cnt_dec = r_cnt - 6'd1;
  assign w_hpat    = HEAD_PAT >> w_cnt_dec;
  assign w_frame   = {in_data0, in_data1, in_data2, in_data3,
                      frame_checksum(in_data0, in_data1,
                                     in_data2, in_data3)};

  // Shift on every edge that moves a payload bit onto the line.
  assign w_shift = ((r_state == HEAD) && (r_cnt == 6'd0)) ||
                   ((r_state == PAYLOAD) && (r_cnt != 6'd0));

  seq_piso u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (w_frame),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_in_ready   <= 1'b0;
      r_data_out   <= IDLE_BIT;
      r_tx_active  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_state     <= HEAD;
            r_cnt       <= 6'(HEAD_LEN - 1);
            r_data_out  <= HEAD_PAT[HEAD_LEN-1];
            r_tx_active <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        HEAD: begin
          if (r_cnt == 6'd0) begin
            r_state    <= PAYLOAD;
            r_cnt      <= 6'(PAYLOAD_BITS - 1);
            r_data_out <= w_msb;
          end else begin
            r_cnt      <= w_cnt_dec;
            r_data_out <= w_hpat[0];
          end
        end
        PAYLOAD: begin
          if (r_cnt == 6'd0) begin
            r_data_out  <= IDLE_BIT;
            r_tx_active <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state    <= IDLE;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= GAP;
              r_cnt   <= 6'(GAP_CYCLES - 1);
            end
          end else begin
            r_cnt        <= w_cnt_dec;
            r_data_out   <= w_msb;
            r_frame_done <= (r_cnt == 6'd1);
          end
        end
        GAP: begin
          if (r_cnt == 6'd0) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign data_out   = r_data_out;
  assign tx_active  = r_tx_active;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seq_wr.sv
// Bench for seq_wr: per-cycle timing model plus directed frame tables.
// Model works from accept/reset times and the frame bit string.
module tb_seq_wr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic [7:0] d2 = 8'h00;
  logic [7:0] d3 = 8'h00;
  logic       in_ready;
  logic       data_out;
  logic       tx_active;
  logic       frame_done;

  seq_wr dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data0   (d0),
    .in_data1   (d1),
    .in_data2   (d2),
    .in_data3   (d3),
    .data_out   (data_out),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] d3;
    logic [7:0] chk;
  } vec_t;

  vec_t tbl [5];

  int          n_vec = 0;
  int          n_err = 0;

  // Reference model: expected line derived from edge offsets.
  int          cyc = 0;
  int          t_acc = -1000;
  int          t_rst = 0;
  int          mk;
  int          ms;
  bit          have = 1'b0;
  bit          armed = 1'b0;
  logic [47:0] m_frame = '0;
  logic        m_ready = 1'b0;
  logic        m_line = 1'b0;
  logic        m_act = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      t_rst = cyc;
      have  = 1'b0;
    end else if (in_valid && m_ready) begin
      ms      = (int'(d0) + int'(d1) + int'(d2) + int'(d3)) % 256;
      t_acc   = cyc;
      have    = 1'b1;
      m_frame = {8'hB1, d0, d1, d2, d3, 8'(ms)};
    end
    mk      = cyc - t_acc;
    m_act   = have && (mk <= 47);
    m_line  = m_act ? m_frame[6'(47 - (m_act ? mk : 0))] : 1'b0;
    m_done  = have && (mk == 47);
    m_ready = (cyc != t_rst) && (!have || mk >= 50);
    armed   = 1'b1;
  end

  task automatic tick();
    @(negedge clk);
    if (armed) begin
      n_vec++;
      if ({data_out, tx_active, frame_done, in_ready} !==
          {m_line, m_act, m_done, m_ready}) begin
        n_err++;
        $display("FAIL cycle %0d line/act/done/rdy got %b expected %b",
                 cyc, {data_out, tx_active, frame_done, in_ready},
                 {m_line, m_act, m_done, m_ready});
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 300) begin
      tick();
      w++;
    end
    check("ready_wait", 64'(in_ready), 64'(1));
  endtask

  task automatic send(input vec_t v, input int stop_k,
                      output logic [47:0] cap, output int done_pos);
    cap      = '0;
    done_pos = -1;
    wait_ready();
    d0 = v.d0; d1 = v.d1; d2 = v.d2; d3 = v.d3;
    in_valid = 1'b1;
    for (int k = 0; k < 48; k++) begin
      tick();
      cap[6'(47 - k)] = data_out;
      if (frame_done) done_pos = k;
      if (k == 0) begin
        in_valid = 1'b0;
        d0 = 8'($urandom); d1 = 8'($urandom);
        d2 = 8'($urandom); d3 = 8'($urandom);
      end
      if (k == stop_k) return;
    end
  endtask

  initial begin
    logic [47:0] cap;
    int          dp;
    int          rises;
    int          zr;
    int          overlap;
    int          dcnt;
    logic        prev;

    tbl[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
    tbl[2] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hC4};
    tbl[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h14};

    tick();
    check("reset_outputs",
          64'({in_ready, data_out, tx_active, frame_done}), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_reset", 64'(in_ready), 64'(1));

    for (int i = 0; i < 5; i++) begin
      send(tbl[i], 99, cap, dp);
      check("header", 64'(cap[47:40]), 64'(8'hB1));
      check("payload", 64'(cap[39:8]),
            64'({tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3}));
      check("checksum", 64'(cap[7:0]), 64'(tbl[i].chk));
      check("done_pos", 64'(dp), 64'(47));
    end

    // Continuous valid: frames must be separated by 3 idle cycles.
    wait_ready();
    in_valid = 1'b1;
    rises = 0; zr = 0; overlap = 0; prev = 1'b0;
    for (int i = 0; i < 153; i++) begin
      d0 = 8'($urandom); d1 = 8'($urandom);
      d2 = 8'($urandom); d3 = 8'($urandom);
      tick();
      if (in_ready && tx_active) overlap++;
      if (tx_active && !prev) begin
        if (rises > 0) check("b2b_gap", 64'(zr), 64'(3));
        rises++;
      end
      zr   = tx_active ? 0 : zr + 1;
      prev = tx_active;
    end
    in_valid = 1'b0;
    check("b2b_frames", 64'(rises), 64'(3));
    check("b2b_overlap", 64'(overlap), 64'(0));

    // Reset at payload bit 10 aborts the frame.
    send(tbl[0], 18, cap, dp);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_line", 64'(data_out), 64'(0));
    check("abort_act", 64'(tx_active), 64'(0));
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (frame_done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'(0));
    send(tbl[4], 99, cap, dp);
    check("post_abort_frame", 64'(cap),
          64'({8'hB1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h14}));
    check("post_abort_done", 64'(dp), 64'(47));

    // Reset and valid together: reset wins.
    wait_ready();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_wins", 64'(tx_active), 64'(0));

    // Random traffic with rare resets.
    dcnt = 0;
    for (int i = 0; i < 6000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 1999) == 0);
      d0 = 8'($urandom); d1 = 8'($urandom);
      d2 = 8'($urandom); d3 = 8'($urandom);
      tick();
      if (frame_done) dcnt++;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("rand_frames_ge_90", 64'(dcnt >= 90), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
